modulo_controle_jogo: RTL and testbench
=======================================

// Module: modulo_controle_jogo
// PURPOSE
// Game sequencer for the single-player battleship datapath on the 5x7 LED matrix.
// - Locks the selected ship preset into the position register.
// - Validates attack coordinates and issues single-cycle writes to the attack register.
// - Counts shots and hits, decides win/loss, and drives the status code and RGB feedback LED.
// - Sits between the debounced buttons and the position/attack matrix registers.
// PARAMETERS
// MAX_SHOTS     20  shots allowed per game (1..35)
// RESULT_CYCLES 4   cycles the hit/miss/reject colour is held (>=1)
// PORTS
// clk         in   1  system clock (the divided tick used by the matrix scan)
// clr         in   1  synchronous reset, active-low
// start       in   1  debounced 1-cycle pulse: new game
// confirm     in   1  debounced 1-cycle pulse: lock preset / fire shot
// coord       in   6  [5:3] column 0..4, [2:0] row 0..6
// ship_cells  in   6  number of ship cells in the currently selected preset
// po_cell     in   1  position-matrix bit at at_idx (combinational lookup)
// at_cell     in   1  attack-matrix bit at at_idx (combinational lookup)
// po_load     out  1  1-cycle strobe: capture preset into the position matrix
// at_write    out  1  1-cycle strobe: set attack bit at at_idx
// at_idx      out  6  latched cell index = row*5+col; matrix bit = 34-at_idx
// state_code  out  2  00 idle, 01 place, 10 attack, 11 game over
// rgb_r       out  1  red feedback
// rgb_g       out  1  green feedback
// hits        out  6  hit counter
// shots       out  6  valid-shot counter
// game_won    out  1  level, high in S_WON
// game_lost   out  1  level, high in S_LOST
// BEHAVIOUR
// - Reset (clr=0 at posedge) applies from any state.
//   - State goes to S_IDLE.
//   - All outputs go to 0; at_idx=0; latched ship_cells goes to 0.
// - All outputs are registered.
// - FSM states: S_IDLE, S_PLACE, S_ATTACK, S_CHECK, S_SHOW, S_WON, S_LOST.
// - S_IDLE --start--> S_PLACE.
//   - hits, shots and rgb are cleared.
// - S_PLACE --confirm--> S_ATTACK, provided ship_cells != 0.
//   - po_load=1 in the next cycle only.
//   - ship_cells is latched.
//   - If ship_cells == 0, confirm is ignored and the state stays in S_PLACE.
// - S_ATTACK --confirm at edge n--> S_CHECK at n+1.
//   - coord is captured and converted to at_idx at edge n.
//   - If col>4 or row>6, a reject flag is latched and at_idx is held at its previous value.
// - S_CHECK lasts 1 cycle; po_cell and at_cell are sampled against the latched at_idx.
//   - Reject when the reject flag is set or at_cell=1.
//   - Not rejected: at edge n+2, at_write=1 for 1 cycle, shots+1, and hits+1 if po_cell=1.
//   - Rejected: no write and no counter change.
// - S_SHOW lasts RESULT_CYCLES cycles (n+2 .. n+1+RESULT_CYCLES).
//   - Hit: rgb_g=1, rgb_r=0.
//   - Miss: rgb_r=1, rgb_g=0.
//   - Reject: rgb_r=1, rgb_g=1.
// - Leaving S_SHOW, priority order:
//   1. hits==ship_cells -> S_WON
//   2. shots==MAX_SHOTS -> S_LOST
//   3. otherwise -> S_ATTACK with rgb=00.
// - S_WON: rgb_g steady 1. S_LOST: rgb_r steady 1.
// - From S_WON or S_LOST, start -> S_PLACE with counters cleared.
// - Ignored inputs:
//   - confirm in S_IDLE, S_CHECK, S_SHOW, S_WON, S_LOST.
//   - start in S_PLACE, S_ATTACK, S_CHECK, S_SHOW.
// - start and confirm high in the same cycle: start wins in states that accept start.
// - Counters never wrap: the game ends at MAX_SHOTS, and hits <= shots.
// - state_code: S_ATTACK, S_CHECK and S_SHOW all report 10.
// TESTING
// 1. Reset: clr=0 mid-S_SHOW -> next cycle S_IDLE, all outputs 0, hits=shots=0.
// 2. Lock: start, ship_cells=9, confirm -> po_load high exactly 1 cycle, state_code 01->10.
//    - Repeat with ship_cells=0 -> no po_load, state stays 01.
// 3. Hit: coord={3'd2,3'd3}, po_cell=1, at_cell=0, confirm at n
//    - at_idx=17.
//    - at_write=1 only at n+2; hits=1, shots=1.
//    - rgb_g=1 for 4 cycles, then back to 10/rgb 00.
// 4. Miss and reject:
//    - po_cell=0 -> red, shots+1.
//    - Repeat the same cell with at_cell=1 -> rgb 11, no at_write, counters unchanged.
//    - coord col=5 -> rgb 11, no at_write, counters unchanged.
// 5. Loss: MAX_SHOTS=3, three misses -> after the third S_SHOW: game_lost=1, rgb_r=1, state_code 11.
//    - Further confirm ignored; start -> S_PLACE, counters 0.
// 6. Win: ship_cells=2, two hits -> game_won=1, rgb_g=1.
//    - start+confirm in the same cycle -> S_PLACE, no po_load.

Source files
------------

// File: rtl/modulo_controle_jogo_if.sv
// Purpose: groups the game sequencer's button, matrix-lookup and status signals into one bundle.
// Latency: none, wires only.
// Backpressure: none; every strobe is a single-cycle pulse with no handshake.
// Ports:
//   start, confirm, coord, ship_cells, po_cell, at_cell  : into the sequencer
//   po_load, at_write, at_idx, state_code, rgb_r, rgb_g,
//   hits, shots, game_won, game_lost                      : out of the sequencer
interface modulo_controle_jogo_if;
  logic       start;
  logic       confirm;
  logic [5:0] coord;
  logic [5:0] ship_cells;
  logic       po_cell;
  logic       at_cell;
  logic       po_load;
  logic       at_write;
  logic [5:0] at_idx;
  logic [1:0] state_code;
  logic       rgb_r;
  logic       rgb_g;
  logic [5:0] hits;
  logic [5:0] shots;
  logic       game_won;
  logic       game_lost;

  // Environment side: buttons and matrix registers.
  modport master (
    output start, confirm, coord, ship_cells, po_cell, at_cell,
    input  po_load, at_write, at_idx, state_code, rgb_r, rgb_g,
           hits, shots, game_won, game_lost
  );

  // Sequencer side.
  modport slave (
    input  start, confirm, coord, ship_cells, po_cell, at_cell,
    output po_load, at_write, at_idx, state_code, rgb_r, rgb_g,
           hits, shots, game_won, game_lost
  );
endinterface

// File: rtl/modulo_controle_jogo.sv
// Purpose: battleship game sequencer; locks the preset, validates and fires shots, scores, shows feedback.
// Latency: confirm seen at edge n -> at_write and counters at edge n+2; every output is registered.
// Backpressure: none; start/confirm arriving in states that do not use them are dropped.
// Ports:
//   clk  - system clock (divided matrix-scan tick)
//   clr  - synchronous reset, active-low
//   bus  - slave side of modulo_controle_jogo_if (buttons, coordinate, matrix lookups, status)
module modulo_controle_jogo #(
  parameter int MAX_SHOTS     = 20,
  parameter int RESULT_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  modulo_controle_jogo_if.slave   bus
);

  localparam int CW = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLACE,
    S_ATTACK,
    S_CHECK,
    S_SHOW,
    S_WON,
    S_LOST
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      at_idx_q, at_idx_d;
  logic [5:0]      ship_q, ship_d;
  logic [5:0]      hits_q, hits_d;
  logic [5:0]      shots_q, shots_d;
  logic            reject_q, reject_d;
  logic [CW-1:0]   show_q, show_d;
  logic            po_load_q, po_load_d;
  logic            at_write_q, at_write_d;
  logic            rgb_r_q, rgb_r_d;
  logic            rgb_g_q, rgb_g_d;
  logic [1:0]      code_q, code_d;
  logic            won_q, won_d;
  logic            lost_q, lost_d;

  // Coordinate decode: column in the upper field, row in the lower one.
  logic [2:0] col;
  logic [2:0] row;
  logic       coord_ok;
  logic [5:0] coord_idx;

  assign col       = bus.coord[5:3];
  assign row       = bus.coord[2:0];
  assign coord_ok  = (col <= 3'd4) && (row <= 3'd6);
  assign coord_idx = 6'(row) * 6'd5 + 6'(col);

  always_comb begin
    state_d    = state_q;
    at_idx_d   = at_idx_q;
    ship_d     = ship_q;
    hits_d     = hits_q;
    shots_d    = shots_q;
    reject_d   = reject_q;
    show_d     = show_q;
    po_load_d  = 1'b0;
    at_write_d = 1'b0;
    rgb_r_d    = rgb_r_q;
    rgb_g_d    = rgb_g_q;

    case (state_q)
      S_IDLE, S_WON, S_LOST: begin
        // start outranks a simultaneous confirm: the confirm is simply dropped.
        if (bus.start) begin
          state_d = S_PLACE;
          hits_d  = '0;
          shots_d = '0;
          rgb_r_d = 1'b0;
          rgb_g_d = 1'b0;
        end
      end

      S_PLACE: begin
        // An empty preset can never be won, so it is not allowed to start a game.
        if (bus.confirm && (bus.ship_cells != 6'd0)) begin
          state_d   = S_ATTACK;
          po_load_d = 1'b1;
          ship_d    = bus.ship_cells;
        end
      end

      S_ATTACK: begin
        if (bus.confirm) begin
          state_d = S_CHECK;
          // Off-board coordinates keep the old index so the lookup stays in range.
          if (coord_ok) begin
            at_idx_d = coord_idx;
            reject_d = 1'b0;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      S_CHECK: begin
        // Matrix lookups are now valid for the latched at_idx.
        state_d = S_SHOW;
        show_d  = CW'(RESULT_CYCLES - 1);
        if (reject_q || bus.at_cell) begin
          rgb_r_d = 1'b1;
          rgb_g_d = 1'b1;
        end else begin
          at_write_d = 1'b1;
          shots_d    = shots_q + 6'd1;
          if (bus.po_cell) begin
            hits_d  = hits_q + 6'd1;
            rgb_r_d = 1'b0;
            rgb_g_d = 1'b1;
          end else begin
            rgb_r_d = 1'b1;
            rgb_g_d = 1'b0;
          end
        end
      end

      S_SHOW: begin
        if (show_q == '0) begin
          // A winning last shot beats running out of shots.
          if (hits_q == ship_q) begin
            state_d = S_WON;
            rgb_r_d = 1'b0;
            rgb_g_d = 1'b1;
          end else if (shots_q == 6'(MAX_SHOTS)) begin
            state_d = S_LOST;
            rgb_r_d = 1'b1;
            rgb_g_d = 1'b0;
          end else begin
            state_d = S_ATTACK;
            rgb_r_d = 1'b0;
            rgb_g_d = 1'b0;
          end
        end else begin
          show_d = show_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    case (state_d)
      S_IDLE:        code_d = 2'b00;
      S_PLACE:       code_d = 2'b01;
      S_WON, S_LOST: code_d = 2'b11;
      default:       code_d = 2'b10;
    endcase
    won_d  = (state_d == S_WON);
    lost_d = (state_d == S_LOST);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= S_IDLE;
      at_idx_q   <= '0;
      ship_q     <= '0;
      hits_q     <= '0;
      shots_q    <= '0;
      reject_q   <= 1'b0;
      show_q     <= '0;
      po_load_q  <= 1'b0;
      at_write_q <= 1'b0;
      rgb_r_q    <= 1'b0;
      rgb_g_q    <= 1'b0;
      code_q     <= 2'b00;
      won_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      at_idx_q   <= at_idx_d;
      ship_q     <= ship_d;
      hits_q     <= hits_d;
      shots_q    <= shots_d;
      reject_q   <= reject_d;
      show_q     <= show_d;
      po_load_q  <= po_load_d;
      at_write_q <= at_write_d;
      rgb_r_q    <= rgb_r_d;
      rgb_g_q    <= rgb_g_d;
      code_q     <= code_d;
      won_q      <= won_d;
      lost_q     <= lost_d;
    end
  end

  assign bus.po_load    = po_load_q;
  assign bus.at_write   = at_write_q;
  assign bus.at_idx     = at_idx_q;
  assign bus.state_code = code_q;
  assign bus.rgb_r      = rgb_r_q;
  assign bus.rgb_g      = rgb_g_q;
  assign bus.hits       = hits_q;
  assign bus.shots      = shots_q;
  assign bus.game_won   = won_q;
  assign bus.game_lost  = lost_q;

endmodule

// File: tb/tb_modulo_controle_jogo.sv
// Purpose: self-checking bench for modulo_controle_jogo, directed scenarios plus randomized games.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; the bench emulates the position/attack matrix registers.
module tb_modulo_controle_jogo;
  localparam int MAXS = 3;
  localparam int RC   = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  modulo_controle_jogo_if ifc ();

  modulo_controle_jogo #(.MAX_SHOTS(MAXS), .RESULT_CYCLES(RC)) dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc)
  );

  int checks   = 0;
  int failures = 0;

  // Emulated matrix registers.
  logic [34:0] po_mem;
  logic [34:0] at_mem;
  assign ifc.po_cell = (ifc.at_idx < 6'd35) ? po_mem[ifc.at_idx] : 1'b0;
  assign ifc.at_cell = (ifc.at_idx < 6'd35) ? at_mem[ifc.at_idx] : 1'b0;
  always @(posedge clk) begin
    if (!clr || ifc.po_load) at_mem <= '0;
    else if (ifc.at_write && ifc.at_idx < 6'd35) at_mem[ifc.at_idx] <= 1'b1;
  end

  // Reference model of the game rules.
  int          m_idx = 0;
  int          m_hits, m_shots, m_ship;
  logic [34:0] m_att;
  logic        e_wr, e_won, e_lost;
  logic [1:0]  e_rgb, e_code, e_rgbp;
  logic [5:0]  e_idx, e_hits, e_shots;

  // Observations from one shot.
  logic [5:0] o_idx1, o_hits2, o_shots2;
  logic       o_wr1, o_wr2, o_hold, o_won, o_lost;
  logic [1:0] o_code1, o_rgb2, o_code_post, o_rgb_post;
  int         o_wrcnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] cell_coord(input int idx);
    return {3'(idx % 5), 3'(idx / 5)};
  endfunction

  function automatic logic [25:0] all_outs();
    return {ifc.po_load, ifc.at_write, ifc.at_idx, ifc.state_code, ifc.rgb_r, ifc.rgb_g,
            ifc.hits, ifc.shots, ifc.game_won, ifc.game_lost};
  endfunction

  task automatic model_lock(input int k);
    m_ship  = k;
    m_hits  = 0;
    m_shots = 0;
    m_att   = '0;
  endtask

  task automatic model_shot(input logic [5:0] c);
    int  col, row;
    bit  rej;
    col = int'(c[5:3]);
    row = int'(c[2:0]);
    if (col < 5 && row < 7) begin
      m_idx = row * 5 + col;
      rej   = m_att[m_idx];
    end else begin
      rej = 1'b1;
    end
    e_idx = 6'(m_idx);
    if (rej) begin
      e_wr  = 1'b0;
      e_rgb = 2'b11;
    end else begin
      e_wr         = 1'b1;
      m_att[m_idx] = 1'b1;
      m_shots++;
      if (po_mem[m_idx]) begin
        m_hits++;
        e_rgb = 2'b01;
      end else begin
        e_rgb = 2'b10;
      end
    end
    e_hits  = 6'(m_hits);
    e_shots = 6'(m_shots);
    if (m_hits == m_ship) begin
      e_code = 2'b11; e_rgbp = 2'b01; e_won = 1'b1; e_lost = 1'b0;
    end else if (m_shots == MAXS) begin
      e_code = 2'b11; e_rgbp = 2'b10; e_won = 1'b0; e_lost = 1'b1;
    end else begin
      e_code = 2'b10; e_rgbp = 2'b00; e_won = 1'b0; e_lost = 1'b0;
    end
  endtask

  // Fires one shot from S_ATTACK and records the whole check/show window.
  task automatic shoot(input logic [5:0] c, input logic st);
    model_shot(c);
    ifc.coord   = c;
    ifc.confirm = 1'b1;
    ifc.start   = st;
    tick();
    ifc.confirm = 1'b0;
    ifc.start   = 1'b0;
    o_idx1  = ifc.at_idx;
    o_wr1   = ifc.at_write;
    o_code1 = ifc.state_code;
    tick();
    o_wr2    = ifc.at_write;
    o_rgb2   = {ifc.rgb_r, ifc.rgb_g};
    o_hits2  = ifc.hits;
    o_shots2 = ifc.shots;
    o_wrcnt  = int'(o_wr2);
    o_hold   = 1'b1;
    for (int k = 1; k < RC; k++) begin
      tick();
      if (ifc.at_write) o_wrcnt++;
      if ({ifc.rgb_r, ifc.rgb_g} !== o_rgb2) o_hold = 1'b0;
    end
    tick();
    o_code_post = ifc.state_code;
    o_rgb_post  = {ifc.rgb_r, ifc.rgb_g};
    o_won       = ifc.game_won;
    o_lost      = ifc.game_lost;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    ifc.start = 1'b0; ifc.confirm = 1'b0; ifc.coord = '0; ifc.ship_cells = '0;
    po_mem = '0;
    tick(); tick();
    checks++;
    if (all_outs() !== 26'd0) begin
      failures++; $display("FAIL reset_outs: got %h want 0", all_outs());
    end
    clr = 1'b1;
    ifc.confirm = 1'b1;
    tick();
    ifc.confirm = 1'b0;
    tick();
    checks++;
    if (all_outs() !== 26'd0) begin
      failures++; $display("FAIL idle_confirm_ignored: got %h want 0", all_outs());
    end
  endtask

  task automatic test_lock();
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    checks++;
    if (ifc.state_code !== 2'b01) begin
      failures++; $display("FAIL lock_place: code %b want 01", ifc.state_code);
    end
    ifc.ship_cells = 6'd0; ifc.confirm = 1'b1; tick(); ifc.confirm = 1'b0;
    checks++;
    if ({ifc.po_load, ifc.state_code} !== 3'b001) begin
      failures++; $display("FAIL lock_zero: po_load/code %b want 001", {ifc.po_load, ifc.state_code});
    end
    ifc.ship_cells = 6'd9; ifc.confirm = 1'b1; tick(); ifc.confirm = 1'b0;
    checks++;
    if ({ifc.po_load, ifc.state_code} !== 3'b110) begin
      failures++; $display("FAIL lock_nine: po_load/code %b want 110", {ifc.po_load, ifc.state_code});
    end
    tick();
    checks++;
    if ({ifc.po_load, ifc.state_code} !== 3'b010) begin
      failures++; $display("FAIL lock_pulse: po_load/code %b want 010", {ifc.po_load, ifc.state_code});
    end
  endtask

  task automatic test_hit();
    po_mem = '0;
    po_mem[17] = 1'b1;
    shoot({3'd2, 3'd3}, 1'b0);
    checks++;
    if ({o_idx1, o_code1} !== {6'd17, 2'b10}) begin
      failures++; $display("FAIL hit_idx: idx %0d code %b want 17 10", o_idx1, o_code1);
    end
    checks++;
    if ({o_wr1, o_wr2} !== 2'b01 || o_wrcnt != 1) begin
      failures++; $display("FAIL hit_write: n+1 %b n+2 %b count %0d want 0 1 1", o_wr1, o_wr2, o_wrcnt);
    end
    checks++;
    if ({o_hold, o_rgb2, o_hits2, o_shots2} !== {1'b1, 2'b01, 6'd1, 6'd1}) begin
      failures++; $display("FAIL hit_show: hold %b rgb %b hits %0d shots %0d want 1 01 1 1",
                           o_hold, o_rgb2, o_hits2, o_shots2);
    end
    checks++;
    if ({o_code_post, o_rgb_post} !== 4'b1000) begin
      failures++; $display("FAIL hit_after: code %b rgb %b want 10 00", o_code_post, o_rgb_post);
    end
  endtask

  task automatic test_miss_reject();
    shoot({3'd0, 3'd0}, 1'b0);
    checks++;
    if ({o_rgb2, o_wrcnt[1:0], o_hits2, o_shots2} !== {2'b10, 2'd1, 6'd1, 6'd2}) begin
      failures++; $display("FAIL miss: rgb %b writes %0d hits %0d shots %0d want 10 1 1 2",
                           o_rgb2, o_wrcnt, o_hits2, o_shots2);
    end
    shoot({3'd0, 3'd0}, 1'b0);
    checks++;
    if ({o_rgb2, o_wrcnt[1:0], o_hits2, o_shots2, o_code_post} !== {2'b11, 2'd0, 6'd1, 6'd2, 2'b10}) begin
      failures++; $display("FAIL reject_repeat: rgb %b writes %0d hits %0d shots %0d code %b want 11 0 1 2 10",
                           o_rgb2, o_wrcnt, o_hits2, o_shots2, o_code_post);
    end
    shoot({3'd5, 3'd2}, 1'b0);
    checks++;
    if ({o_rgb2, o_wrcnt[1:0], o_idx1, o_hits2, o_shots2} !== {2'b11, 2'd0, 6'd0, 6'd1, 6'd2}) begin
      failures++; $display("FAIL reject_col5: rgb %b writes %0d idx %0d hits %0d shots %0d want 11 0 0 1 2",
                           o_rgb2, o_wrcnt, o_idx1, o_hits2, o_shots2);
    end
    // Third valid shot exhausts the budget.
    shoot({3'd1, 3'd0}, 1'b0);
    checks++;
    if ({o_code_post, o_rgb_post, o_won, o_lost} !== {2'b11, 2'b10, 1'b0, 1'b1}) begin
      failures++; $display("FAIL miss_budget_end: code %b rgb %b won %b lost %b want 11 10 0 1",
                           o_code_post, o_rgb_post, o_won, o_lost);
    end
  endtask

  task automatic test_loss();
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    checks++;
    if ({ifc.state_code, ifc.hits, ifc.shots, ifc.game_lost, ifc.rgb_r, ifc.rgb_g} !== {2'b01, 15'd0}) begin
      failures++; $display("FAIL loss_restart: code %b hits %0d shots %0d lost %b want 01 0 0 0",
                           ifc.state_code, ifc.hits, ifc.shots, ifc.game_lost);
    end
    po_mem = '0;
    ifc.ship_cells = 6'd4; ifc.confirm = 1'b1; tick(); ifc.confirm = 1'b0;
    for (int i = 1; i <= 3; i++) shoot({3'd0, 3'(i)}, 1'b0);
    checks++;
    if ({o_code_post, o_rgb_post, o_won, o_lost, o_shots2} !== {2'b11, 2'b10, 1'b0, 1'b1, 6'd3}) begin
      failures++; $display("FAIL loss_end: code %b rgb %b won %b lost %b shots %0d want 11 10 0 1 3",
                           o_code_post, o_rgb_post, o_won, o_lost, o_shots2);
    end
    for (int i = 0; i < 2; i++) begin
      ifc.coord = {3'd4, 3'd4}; ifc.confirm = 1'b1; tick(); ifc.confirm = 1'b0; tick();
      checks++;
      if ({ifc.state_code, ifc.at_write, ifc.po_load, ifc.shots, ifc.game_lost} !== {2'b11, 2'b00, 6'd3, 1'b1}) begin
        failures++; $display("FAIL loss_confirm_ignored: code %b wr %b ld %b shots %0d want 11 0 0 3",
                             ifc.state_code, ifc.at_write, ifc.po_load, ifc.shots);
      end
    end
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    checks++;
    if ({ifc.state_code, ifc.hits, ifc.shots, ifc.game_lost} !== {2'b01, 13'd0}) begin
      failures++; $display("FAIL loss_start: code %b hits %0d shots %0d lost %b want 01 0 0 0",
                           ifc.state_code, ifc.hits, ifc.shots, ifc.game_lost);
    end
  endtask

  task automatic test_win();
    po_mem = '0;
    po_mem[8]  = 1'b1;
    po_mem[30] = 1'b1;
    ifc.ship_cells = 6'd2; ifc.confirm = 1'b1; tick(); ifc.confirm = 1'b0;
    shoot({3'd3, 3'd1}, 1'b0);
    checks++;
    if ({o_idx1, o_rgb2, o_code_post} !== {6'd8, 2'b01, 2'b10}) begin
      failures++; $display("FAIL win_first: idx %0d rgb %b code %b want 8 01 10", o_idx1, o_rgb2, o_code_post);
    end
    shoot({3'd0, 3'd6}, 1'b0);
    checks++;
    if ({o_code_post, o_rgb_post, o_won, o_lost, o_hits2} !== {2'b11, 2'b01, 1'b1, 1'b0, 6'd2}) begin
      failures++; $display("FAIL win_end: code %b rgb %b won %b lost %b hits %0d want 11 01 1 0 2",
                           o_code_post, o_rgb_post, o_won, o_lost, o_hits2);
    end
    ifc.ship_cells = 6'd5; ifc.start = 1'b1; ifc.confirm = 1'b1; tick();
    ifc.start = 1'b0; ifc.confirm = 1'b0;
    checks++;
    if ({ifc.state_code, ifc.po_load, ifc.game_won} !== 4'b0100) begin
      failures++; $display("FAIL win_start_confirm: code %b ld %b won %b want 01 0 0",
                           ifc.state_code, ifc.po_load, ifc.game_won);
    end
    tick();
    checks++;
    if ({ifc.state_code, ifc.po_load} !== 3'b010) begin
      failures++; $display("FAIL win_no_load: code %b ld %b want 01 0", ifc.state_code, ifc.po_load);
    end
  endtask

  // Random games from S_PLACE; each ends back in S_PLACE.
  task automatic test_random_games();
    for (int g = 0; g < 6; g++) begin
      int k;
      bit over;
      k = int'($urandom_range(1, 3));
      po_mem = '0;
      while ($countones(po_mem) < k) po_mem[$urandom_range(0, 34)] = 1'b1;
      ifc.ship_cells = 6'(k); ifc.confirm = 1'b1; tick(); ifc.confirm = 1'b0;
      model_lock(k);
      checks++;
      if ({ifc.po_load, ifc.state_code} !== 3'b110) begin
        failures++; $display("FAIL rnd_lock g%0d: ld/code %b want 110", g, {ifc.po_load, ifc.state_code});
      end
      over = 1'b0;
      for (int it = 0; it < 20 && !over; it++) begin
        logic [5:0] c;
        int sel;
        sel = int'($urandom_range(0, 99));
        if (it >= 12) begin
          c = '0;
          for (int i = 34; i >= 0; i--) if (!m_att[i]) c = cell_coord(i);
        end else if (sel < 15) begin
          c = ($urandom_range(0, 1) == 0) ? {3'($urandom_range(5, 7)), 3'($urandom_range(0, 7))}
                                          : {3'($urandom_range(0, 4)), 3'd7};
        end else if (sel < 55) begin
          int p;
          p = int'($urandom_range(0, 34));
          while (!po_mem[p]) p = (p + 1) % 35;
          c = cell_coord(p);
        end else begin
          c = cell_coord(int'($urandom_range(0, 34)));
        end
        shoot(c, 1'($urandom_range(0, 3) == 0));
        checks++;
        if (o_idx1 !== e_idx || o_code1 !== 2'b10) begin
          failures++; $display("FAIL rnd_idx g%0d s%0d: idx %0d code %b want %0d 10", g, it, o_idx1, o_code1, e_idx);
        end
        checks++;
        if ({o_wr1, o_wr2} !== {1'b0, e_wr} || o_wrcnt != int'(e_wr)) begin
          failures++; $display("FAIL rnd_write g%0d s%0d: %b%b count %0d want 0%b", g, it, o_wr1, o_wr2, o_wrcnt, e_wr);
        end
        checks++;
        if ({o_hold, o_rgb2} !== {1'b1, e_rgb}) begin
          failures++; $display("FAIL rnd_rgb g%0d s%0d: hold %b rgb %b want 1 %b", g, it, o_hold, o_rgb2, e_rgb);
        end
        checks++;
        if ({o_hits2, o_shots2} !== {e_hits, e_shots}) begin
          failures++; $display("FAIL rnd_count g%0d s%0d: hits %0d shots %0d want %0d %0d",
                               g, it, o_hits2, o_shots2, e_hits, e_shots);
        end
        checks++;
        if ({o_code_post, o_rgb_post, o_won, o_lost} !== {e_code, e_rgbp, e_won, e_lost}) begin
          failures++; $display("FAIL rnd_after g%0d s%0d: code %b rgb %b won %b lost %b want %b %b %b %b",
                               g, it, o_code_post, o_rgb_post, o_won, o_lost, e_code, e_rgbp, e_won, e_lost);
        end
        over = e_won || e_lost;
      end
      checks++;
      if (!over) begin
        failures++; $display("FAIL rnd_game_end g%0d: game not over within bound, want over", g);
      end
      ifc.start = 1'b1; tick(); ifc.start = 1'b0;
      checks++;
      if ({ifc.state_code, ifc.hits, ifc.shots, ifc.game_won, ifc.game_lost} !== {2'b01, 14'd0}) begin
        failures++; $display("FAIL rnd_restart g%0d: code %b hits %0d shots %0d want 01 0 0",
                             g, ifc.state_code, ifc.hits, ifc.shots);
      end
    end
  endtask

  task automatic test_reset_mid_show();
    po_mem = '0;
    po_mem[6] = 1'b1;
    ifc.ship_cells = 6'd3; ifc.confirm = 1'b1; tick(); ifc.confirm = 1'b0;
    ifc.coord = {3'd1, 3'd1}; ifc.confirm = 1'b1; tick(); ifc.confirm = 1'b0;
    tick(); tick();
    checks++;
    if ({ifc.rgb_r, ifc.rgb_g, ifc.hits} !== {2'b01, 6'd1}) begin
      failures++; $display("FAIL midshow_setup: rgb %b hits %0d want 01 1", {ifc.rgb_r, ifc.rgb_g}, ifc.hits);
    end
    clr = 1'b0; tick(); clr = 1'b1;
    m_idx = 0;
    checks++;
    if (all_outs() !== 26'd0) begin
      failures++; $display("FAIL midshow_reset: got %h want 0", all_outs());
    end
    tick();
    checks++;
    if (ifc.state_code !== 2'b00) begin
      failures++; $display("FAIL midshow_idle: code %b want 00", ifc.state_code);
    end
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    checks++;
    if (ifc.state_code !== 2'b01) begin
      failures++; $display("FAIL midshow_start: code %b want 01", ifc.state_code);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_hit();
    test_miss_reject();
    test_loss();
    test_win();
    test_random_games();
    test_reset_mid_show();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
